// File: rtl/maze_game_ctrl_if.sv
// Bundle between maze_game_ctrl and its surroundings (buttons, map ROM,
// renderer/SSD).
//   master: controller side. Takes the button strobes and ROM row in, and
//           drives the ROM address and the game status out.
//   slave : environment side (buttons, ROM, display).
interface maze_game_ctrl_if #(
  parameter int unsigned MAP_W   = 30,
  parameter int unsigned MAP_H   = 21,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned AW = (MAP_H > 1) ? $clog2(MAP_H) : 1;

  logic [3:0]         move_pulse;
  logic               select_pulse;
  logic [AW-1:0]      map_addr;
  logic [MAP_W-1:0]   map_row;
  logic [COORD_W-1:0] player_x;
  logic [COORD_W-1:0] player_y;
  logic [2:0]         state;
  logic [1:0]         difficulty;
  logic               show_map;
  logic               lost;
  logic               won;
  logic [CNT_W-1:0]   move_count;

  modport master (
    input  move_pulse, select_pulse, map_row,
    output map_addr, player_x, player_y, state, difficulty,
           show_map, lost, won, move_count
  );

  modport slave (
    output move_pulse, select_pulse, map_row,
    input  map_addr, player_x, player_y, state, difficulty,
           show_map, lost, won, move_count
  );
endinterface

// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: menu/difficulty selection, timed map preview, player
// movement with wall collision against an external synchronous map ROM,
// and win/loss detection.
// Ports: clk, reset (async, active-high), bus (maze_game_ctrl_if.master):
//   move_pulse/select_pulse in, map_row in (one cycle after map_addr),
//   map_addr, player_x/y, state, difficulty, show_map, lost, won and
//   move_count out. All outputs are registered.
// Optional: define MAZE_HINT_EN to build the one-shot in-game map hint.
module maze_game_ctrl #(
  parameter int unsigned MAP_W      = 30,
  parameter int unsigned MAP_H      = 21,
  parameter int unsigned COORD_W    = 8,
  parameter int unsigned START_X    = 0,
  parameter int unsigned START_Y    = 20,
  parameter int unsigned GOAL_X     = 29,
  parameter int unsigned GOAL_Y     = 0,
  parameter int unsigned SHOW_EASY  = 300_000_000,
  parameter int unsigned SHOW_MED   = 150_000_000,
  parameter int unsigned SHOW_HARD  = 50_000_000,
  parameter int unsigned HINT_TICKS = 100_000_000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  maze_game_ctrl_if.master bus
);
  localparam int unsigned AW  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned XW  = COORD_W + 1;
  // One width that fits both the preview and the hint countdowns.
  localparam int unsigned TMR_MAX1 = (SHOW_EASY > SHOW_MED) ? SHOW_EASY : SHOW_MED;
  localparam int unsigned TMR_MAX2 = (SHOW_HARD > HINT_TICKS) ? SHOW_HARD : HINT_TICKS;
  localparam int unsigned TMR_MAX  = (TMR_MAX1 > TMR_MAX2) ? TMR_MAX1 : TMR_MAX2;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    MENU  = 3'd0,
    SHOW  = 3'd1,
    PLAY  = 3'd2,
    FETCH = 3'd3,
    CHECK = 3'd4,
    LOST  = 3'd5,
    WON   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         diff_q, diff_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d, tx_q, tx_d, ty_q, ty_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               show_q, show_d, lost_q, lost_d, won_q, won_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
`ifdef MAZE_HINT_EN
  logic [TMR_W-1:0]   hint_q, hint_d;
  logic               hint_used_q, hint_used_d;
`endif

  // Candidate target cell. A negative result wraps to a value >= 2^COORD_W,
  // so a single unsigned compare also rejects moves off the low edges.
  logic [XW-1:0] tgt_x_c, tgt_y_c;
  logic          in_bounds_c, one_hot_c, wall_c;

  always_comb begin
    tgt_x_c = {1'b0, px_q};
    tgt_y_c = {1'b0, py_q};
    if (bus.move_pulse[0])      tgt_y_c = {1'b0, py_q} - XW'(1);
    else if (bus.move_pulse[1]) tgt_y_c = {1'b0, py_q} + XW'(1);
    else if (bus.move_pulse[2]) tgt_x_c = {1'b0, px_q} - XW'(1);
    else if (bus.move_pulse[3]) tgt_x_c = {1'b0, px_q} + XW'(1);
    one_hot_c   = $onehot(bus.move_pulse);
    in_bounds_c = (tgt_x_c < XW'(MAP_W)) && (tgt_y_c < XW'(MAP_H));
    wall_c      = |(bus.map_row & (MAP_W'(1) << tx_q));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    diff_d  = diff_q;
    px_d    = px_q;
    py_d    = py_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    addr_d  = addr_q;
    show_d  = show_q;
    lost_d  = lost_q;
    won_d   = won_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
`ifdef MAZE_HINT_EN
    hint_d      = hint_q;
    hint_used_d = hint_used_q;
    // Running hint counts down independently of the movement FSM.
    if (hint_q != '0) begin
      hint_d = hint_q - TMR_W'(1);
      if (hint_q == TMR_W'(1)) show_d = 1'b0;
    end
`endif

    case (state_q)
      MENU: begin
        if (bus.move_pulse[0] && !bus.move_pulse[1])
          diff_d = (diff_q == 2'd0) ? 2'd2 : diff_q - 2'd1;
        else if (bus.move_pulse[1] && !bus.move_pulse[0])
          diff_d = (diff_q == 2'd2) ? 2'd0 : diff_q + 2'd1;
        if (bus.select_pulse) begin
          case (diff_q)
            2'd1:    tmr_d = TMR_W'(SHOW_MED);
            2'd2:    tmr_d = TMR_W'(SHOW_HARD);
            default: tmr_d = TMR_W'(SHOW_EASY);
          endcase
          show_d  = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (tmr_q <= TMR_W'(1)) begin
          tmr_d   = '0;
          show_d  = 1'b0;
          state_d = PLAY;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      PLAY: begin
        if (one_hot_c && in_bounds_c) begin
          tx_d    = tgt_x_c[COORD_W-1:0];
          ty_d    = tgt_y_c[COORD_W-1:0];
          addr_d  = AW'(tgt_y_c);
          state_d = FETCH;
        end
`ifdef MAZE_HINT_EN
        if (bus.select_pulse && !hint_used_q) begin
          hint_d      = TMR_W'(HINT_TICKS);
          hint_used_d = 1'b1;
          show_d      = 1'b1;
        end
`endif
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        px_d = tx_q;
        py_d = ty_q;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (wall_c) begin
          lost_d  = 1'b1;
          state_d = LOST;
        end else if (tx_q == COORD_W'(GOAL_X) && ty_q == COORD_W'(GOAL_Y)) begin
          won_d   = 1'b1;
          state_d = WON;
        end else begin
          state_d = PLAY;
        end
`ifdef MAZE_HINT_EN
        if (wall_c || (tx_q == COORD_W'(GOAL_X) && ty_q == COORD_W'(GOAL_Y))) begin
          hint_d = '0;
          show_d = 1'b0;
        end
`endif
      end
      LOST, WON: begin
        if (bus.select_pulse) begin
          px_d    = COORD_W'(START_X);
          py_d    = COORD_W'(START_Y);
          cnt_d   = '0;
          lost_d  = 1'b0;
          won_d   = 1'b0;
          state_d = MENU;
`ifdef MAZE_HINT_EN
          hint_used_d = 1'b0;
`endif
        end
      end
      default: state_d = MENU;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MENU;
      diff_q  <= 2'd0;
      px_q    <= COORD_W'(START_X);
      py_q    <= COORD_W'(START_Y);
      tx_q    <= '0;
      ty_q    <= '0;
      addr_q  <= '0;
      show_q  <= 1'b0;
      lost_q  <= 1'b0;
      won_q   <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
`ifdef MAZE_HINT_EN
      hint_q      <= '0;
      hint_used_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      diff_q  <= diff_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      addr_q  <= addr_d;
      show_q  <= show_d;
      lost_q  <= lost_d;
      won_q   <= won_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
`ifdef MAZE_HINT_EN
      hint_q      <= hint_d;
      hint_used_q <= hint_used_d;
`endif
    end
  end

  assign bus.map_addr   = addr_q;
  assign bus.player_x   = px_q;
  assign bus.player_y   = py_q;
  assign bus.state      = state_q;
  assign bus.difficulty = diff_q;
  assign bus.show_map   = show_q;
  assign bus.lost       = lost_q;
  assign bus.won        = won_q;
  assign bus.move_count = cnt_q;
endmodule

// File: tb/tb_maze_game_ctrl.sv
// Self-checking bench for maze_game_ctrl: directed scenarios plus a
// randomized walk over a random maze, checked against a cell-level model.
module tb_maze_game_ctrl;
  localparam int unsigned MAP_W = 30, MAP_H = 21, COORD_W = 8, CNT_W = 16;
  localparam int unsigned SX = 0, SY = 20, GX = 29, GY = 0;
  localparam int unsigned S_E = 5, S_M = 3, S_H = 2, HINT_LEN = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int m_diff = 0;
  int show_len [3] = '{S_E, S_M, S_H};
  logic [MAP_W-1:0] rom [MAP_H];

  maze_game_ctrl_if #(.MAP_W(MAP_W), .MAP_H(MAP_H), .COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

  maze_game_ctrl #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .COORD_W(COORD_W),
    .START_X(SX), .START_Y(SY), .GOAL_X(GX), .GOAL_Y(GY),
    .SHOW_EASY(S_E), .SHOW_MED(S_M), .SHOW_HARD(S_H),
    .HINT_TICKS(HINT_LEN), .CNT_W(CNT_W)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) bus.map_row <= rom[bus.map_addr];

  task automatic clear_rom();
    for (int r = 0; r < int'(MAP_H); r++) rom[r] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.move_pulse = 4'd0;
    bus.select_pulse = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_diff = 0;
  endtask

  // Drive a one-cycle strobe; returns at the negedge after the sampling edge.
  task automatic do_pulse(input logic [3:0] mv, input logic sel);
    @(negedge clk);
    bus.move_pulse = mv;
    bus.select_pulse = sel;
    @(negedge clk);
    bus.move_pulse = 4'd0;
    bus.select_pulse = 1'b0;
  endtask

  task automatic do_move(input logic [3:0] mv);
    do_pulse(mv, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic start_game();
    do_pulse(4'd0, 1'b1);
    repeat (show_len[m_diff]) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.state !== 3'd0 || bus.player_x !== 8'(SX) || bus.player_y !== 8'(SY) ||
        bus.difficulty !== 2'd0 || bus.map_addr !== 5'd0 || bus.show_map !== 1'b0 ||
        bus.lost !== 1'b0 || bus.won !== 1'b0 || bus.move_count !== 16'd0) begin
      failures++;
      $display("FAIL reset: state=%0d pos=(%0d,%0d) diff=%0d addr=%0d show=%b lost=%b won=%b cnt=%0d, expected all reset values",
               bus.state, bus.player_x, bus.player_y, bus.difficulty, bus.map_addr,
               bus.show_map, bus.lost, bus.won, bus.move_count);
    end
  endtask

  task automatic test_menu();
    int exp_seq [3] = '{1, 2, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_pulse(4'b0010, 1'b0);
      checks++;
      if (bus.difficulty !== 2'(exp_seq[i])) begin
        failures++;
        $display("FAIL menu_down%0d: difficulty=%0d expected %0d", i, bus.difficulty, exp_seq[i]);
      end
    end
    do_pulse(4'b0001, 1'b0);
    checks++;
    if (bus.difficulty !== 2'd2) begin
      failures++;
      $display("FAIL menu_up_wrap: difficulty=%0d expected 2", bus.difficulty);
    end
    do_pulse(4'b1100, 1'b0);
    checks++;
    if (bus.difficulty !== 2'd2 || bus.state !== 3'd0) begin
      failures++;
      $display("FAIL menu_other_bits: difficulty=%0d state=%0d expected 2/0", bus.difficulty, bus.state);
    end
  endtask

  task automatic test_show();
    int n = 0;
    clear_rom();
    do_reset();
    do_pulse(4'd0, 1'b1);
    checks++;
    if (bus.state !== 3'd1) begin
      failures++;
      $display("FAIL show_enter: state=%0d expected 1", bus.state);
    end
    while (bus.show_map === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != int'(S_E) || bus.state !== 3'd2) begin
      failures++;
      $display("FAIL show_len: cycles=%0d state=%0d expected %0d cycles then 2", n, bus.state, S_E);
    end
    checks++;
    if (bus.player_x !== 8'(SX) || bus.player_y !== 8'(SY)) begin
      failures++;
      $display("FAIL show_pos: pos=(%0d,%0d) expected (%0d,%0d)", bus.player_x, bus.player_y, SX, SY);
    end
  endtask

  task automatic test_move_basic();
    do_pulse(4'b1000, 1'b0);
    checks++;
    if (bus.state !== 3'd3 || bus.map_addr !== 5'd20) begin
      failures++;
      $display("FAIL move_fetch: state=%0d addr=%0d expected 3/20", bus.state, bus.map_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd4 || bus.player_x !== 8'd0) begin
      failures++;
      $display("FAIL move_check: state=%0d x=%0d expected 4/0", bus.state, bus.player_x);
    end
    @(negedge clk);
    checks++;
    if (bus.player_x !== 8'd1 || bus.player_y !== 8'd20 || bus.move_count !== 16'd1 || bus.state !== 3'd2) begin
      failures++;
      $display("FAIL move_done: pos=(%0d,%0d) cnt=%0d state=%0d expected (1,20)/1/2",
               bus.player_x, bus.player_y, bus.move_count, bus.state);
    end
  endtask

  task automatic test_border();
    logic [3:0] pats [4] = '{4'b0100, 4'b0010, 4'b0011, 4'b0000};
    clear_rom();
    do_reset();
    start_game();
    for (int i = 0; i < 4; i++) begin
      do_pulse(pats[i], 1'b0);
      checks++;
      if (bus.state !== 3'd2) begin
        failures++;
        $display("FAIL border_nofetch[%b]: state=%0d expected 2", pats[i], bus.state);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.move_count !== 16'd0 || bus.player_x !== 8'd0 || bus.player_y !== 8'd20) begin
        failures++;
        $display("FAIL border_nomove[%b]: cnt=%0d pos=(%0d,%0d) expected 0/(0,20)",
                 pats[i], bus.move_count, bus.player_x, bus.player_y);
      end
    end
  endtask

  task automatic test_wall_lost();
    clear_rom();
    rom[19] = 30'd1;
    do_reset();
    do_pulse(4'b0001, 1'b0);
    m_diff = 2;
    start_game();
    do_pulse(4'b0001, 1'b0);
    checks++;
    if (bus.map_addr !== 5'd19) begin
      failures++;
      $display("FAIL wall_addr: addr=%0d expected 19", bus.map_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.player_x !== 8'd0 || bus.player_y !== 8'd19 || bus.lost !== 1'b1 || bus.state !== 3'd5 || bus.won !== 1'b0) begin
      failures++;
      $display("FAIL wall_lost: pos=(%0d,%0d) lost=%b won=%b state=%0d expected (0,19)/1/0/5",
               bus.player_x, bus.player_y, bus.lost, bus.won, bus.state);
    end
    do_move(4'b1000);
    checks++;
    if (bus.state !== 3'd5 || bus.player_x !== 8'd0) begin
      failures++;
      $display("FAIL lost_ignore_move: state=%0d x=%0d expected 5/0", bus.state, bus.player_x);
    end
    do_pulse(4'd0, 1'b1);
    checks++;
    if (bus.state !== 3'd0 || bus.player_x !== 8'd0 || bus.player_y !== 8'd20 ||
        bus.lost !== 1'b0 || bus.move_count !== 16'd0 || bus.difficulty !== 2'd2) begin
      failures++;
      $display("FAIL lost_to_menu: state=%0d pos=(%0d,%0d) lost=%b cnt=%0d diff=%0d expected 0/(0,20)/0/0/2",
               bus.state, bus.player_x, bus.player_y, bus.lost, bus.move_count, bus.difficulty);
    end
  endtask

  task automatic test_win();
    clear_rom();
    do_reset();
    start_game();
    for (int i = 0; i < 20; i++) do_move(4'b0001);
    for (int i = 0; i < 28; i++) do_move(4'b1000);
    checks++;
    if (bus.won !== 1'b0 || bus.state !== 3'd2 || bus.player_x !== 8'd28) begin
      failures++;
      $display("FAIL win_before: won=%b state=%0d x=%0d expected 0/2/28", bus.won, bus.state, bus.player_x);
    end
    do_move(4'b1000);
    checks++;
    if (bus.won !== 1'b1 || bus.state !== 3'd6 || bus.player_x !== 8'd29 || bus.player_y !== 8'd0 ||
        bus.move_count !== 16'd49 || bus.lost !== 1'b0) begin
      failures++;
      $display("FAIL win_reach: won=%b state=%0d pos=(%0d,%0d) cnt=%0d expected 1/6/(29,0)/49",
               bus.won, bus.state, bus.player_x, bus.player_y, bus.move_count);
    end
    do_move(4'b0100);
    checks++;
    if (bus.state !== 3'd6 || bus.player_x !== 8'd29 || bus.move_count !== 16'd49) begin
      failures++;
      $display("FAIL won_ignore_move: state=%0d x=%0d cnt=%0d expected 6/29/49", bus.state, bus.player_x, bus.move_count);
    end
    do_pulse(4'd0, 1'b1);
    checks++;
    if (bus.state !== 3'd0 || bus.won !== 1'b0) begin
      failures++;
      $display("FAIL won_to_menu: state=%0d won=%b expected 0/0", bus.state, bus.won);
    end
  endtask

  task automatic test_reset_fetch();
    clear_rom();
    do_reset();
    start_game();
    do_pulse(4'b0001, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.map_addr !== 5'd0 || bus.player_x !== 8'(SX) ||
        bus.player_y !== 8'(SY) || bus.show_map !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fetch: state=%0d addr=%0d pos=(%0d,%0d) show=%b expected 0/0/(0,20)/0",
               bus.state, bus.map_addr, bus.player_x, bus.player_y, bus.show_map);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hint();
    int n = 0;
    clear_rom();
    do_reset();
    start_game();
    do_pulse(4'd0, 1'b1);
`ifdef MAZE_HINT_EN
    while (bus.show_map === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != int'(HINT_LEN) || bus.state !== 3'd2) begin
      failures++;
      $display("FAIL hint_len: cycles=%0d state=%0d expected %0d/2", n, bus.state, HINT_LEN);
    end
    do_pulse(4'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.show_map !== 1'b0) begin
      failures++;
      $display("FAIL hint_once: show=%b expected 0", bus.show_map);
    end
`else
    repeat (3) begin
      if (bus.show_map === 1'b1) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 0 || bus.state !== 3'd2 || bus.move_count !== 16'd0) begin
      failures++;
      $display("FAIL select_in_play: show_cycles=%0d state=%0d cnt=%0d expected 0/2/0", n, bus.state, bus.move_count);
    end
`endif
  endtask

  // Random maze, random strobes; the model tracks the player cell by cell.
  task automatic test_random();
    int x, y, cnt, st, nx, ny;
    logic [3:0] mv;
    logic valid;
    for (int r = 0; r < int'(MAP_H); r++) rom[r] = 30'($urandom & $urandom & $urandom);
    rom[SY][SX] = 1'b0;
    rom[GY][GX] = 1'b0;
    do_reset();
    for (int g = 0; g < 6; g++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_pulse(4'b0010, 1'b0);
        m_diff = (m_diff + 1) % 3;
      end else begin
        do_pulse(4'b0001, 1'b0);
        m_diff = (m_diff + 2) % 3;
      end
      checks++;
      if (bus.difficulty !== 2'(m_diff)) begin
        failures++;
        $display("FAIL rnd_diff g%0d: difficulty=%0d expected %0d", g, bus.difficulty, m_diff);
      end
      start_game();
      x = int'(SX); y = int'(SY); cnt = 0; st = 2;
      for (int k = 0; k < 60 && st == 2; k++) begin
        if ($urandom_range(0, 3) == 0) mv = 4'($urandom_range(0, 15));
        else mv = 4'(1 << $urandom_range(0, 3));
        nx = x; ny = y;
        if (mv == 4'b0001) ny = y - 1;
        if (mv == 4'b0010) ny = y + 1;
        if (mv == 4'b0100) nx = x - 1;
        if (mv == 4'b1000) nx = x + 1;
        valid = ($countones(mv) == 1) && nx >= 0 && nx < int'(MAP_W) && ny >= 0 && ny < int'(MAP_H);
        do_pulse(mv, 1'b0);
        checks++;
        if (bus.state !== (valid ? 3'd3 : 3'd2) || (valid && bus.map_addr !== 5'(ny))) begin
          failures++;
          $display("FAIL rnd_accept g%0d k%0d mv=%b: state=%0d addr=%0d expected state %0d addr %0d",
                   g, k, mv, bus.state, bus.map_addr, valid ? 3 : 2, ny);
        end
        if (valid) begin
          x = nx; y = ny; cnt++;
          if (rom[y][x]) st = 5;
          else if (x == int'(GX) && y == int'(GY)) st = 6;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.player_x !== 8'(x) || bus.player_y !== 8'(y) || bus.move_count !== 16'(cnt) ||
            bus.state !== 3'(st) || bus.lost !== (st == 5) || bus.won !== (st == 6)) begin
          failures++;
          $display("FAIL rnd_result g%0d k%0d mv=%b: pos=(%0d,%0d) cnt=%0d state=%0d lost=%b won=%b expected (%0d,%0d)/%0d/%0d",
                   g, k, mv, bus.player_x, bus.player_y, bus.move_count, bus.state, bus.lost, bus.won, x, y, cnt, st);
        end
      end
      if (st == 2) begin
        do_reset();
      end else begin
        do_pulse(4'd0, 1'b1);
        checks++;
        if (bus.state !== 3'd0 || bus.move_count !== 16'd0 || bus.player_y !== 8'(SY) || bus.difficulty !== 2'(m_diff)) begin
          failures++;
          $display("FAIL rnd_menu g%0d: state=%0d cnt=%0d y=%0d diff=%0d expected 0/0/%0d/%0d",
                   g, bus.state, bus.move_count, bus.player_y, bus.difficulty, SY, m_diff);
        end
      end
    end
  endtask

  initial begin
    bus.move_pulse = 4'd0;
    bus.select_pulse = 1'b0;
    clear_rom();
    test_reset();
    test_menu();
    test_show();
    test_move_basic();
    test_border();
    test_wall_lost();
    test_win();
    test_reset_fetch();
    test_hint();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
